// File: rtl/wb_atomic_unit.sv
// Wishbone atomic RMW unit: CAS / SWAP / ADD / AND through a 32-byte register window.
// Optional bus-retry handling is enabled by defining WB_ATOMIC_RETRY_EN.
module wb_atomic_unit #(
  parameter int              DW        = 32,
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   WIN_BASE  = 32'hFFFF_FF00,
  parameter int              MAX_RETRY = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   wb_core_adr_i,
  input  logic [DW-1:0]   wb_core_dat_i,
  output logic [DW-1:0]   wb_core_dat_o,
  input  logic [DW/8-1:0] wb_core_sel_i,
  input  logic            wb_core_we_i,
  input  logic            wb_core_cyc_i,
  input  logic            wb_core_stb_i,
  output logic            wb_core_ack_o,
  output logic            wb_core_err_o,
  output logic            wb_core_rty_o,
  output logic [AW-1:0]   wb_bus_adr_o,
  output logic [DW-1:0]   wb_bus_dat_o,
  input  logic [DW-1:0]   wb_bus_dat_i,
  output logic [DW/8-1:0] wb_bus_sel_o,
  output logic            wb_bus_we_o,
  output logic            wb_bus_cyc_o,
  output logic            wb_bus_stb_o,
  input  logic            wb_bus_ack_i,
  input  logic            wb_bus_err_i,
  input  logic            wb_bus_rty_i,
  output logic            bus_lock_o
);

  localparam int SW = DW / 8;
`ifdef WB_ATOMIC_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int RETRY_LIMIT = RETRY_EN ? MAX_RETRY : 0;

  localparam logic [1:0] RK_OK  = 2'd0;
  localparam logic [1:0] RK_ERR = 2'd1;
  localparam logic [1:0] RK_RTY = 2'd2;

  typedef enum logic [2:0] {IDLE, REGACK, RD, WR, RESP} state_t;
  state_t state_reg, state_next;

  logic [DW-1:0] opa_reg, opb_reg, tadr_reg, rdata_reg, old_reg, new_reg;
  logic [1:0]    op_reg, status_reg, resp_kind_reg, gap_reg;
  logic [7:0]    retry_reg;
  logic          dropped_reg;

  logic          req, hit, exec_rd, strobing;
  logic          ack_ev, rty_ev, retry_ok, fail_err, fail_rty, need_write;
  logic [2:0]    reg_idx;
  logic [DW-1:0] wmask, reg_rd, new_val;
  logic [AW-1:0] tadr_adr;

  assign req      = wb_core_cyc_i & wb_core_stb_i;
  assign hit      = (wb_core_adr_i[AW-1:5] == WIN_BASE[AW-1:5]);
  assign reg_idx  = wb_core_adr_i[4:2];
  assign exec_rd  = hit & ~wb_core_we_i & (reg_idx == 3'd4);

  // Bus responses only count while the strobe is actually asserted.
  assign strobing = (gap_reg == 2'd0);
  assign rty_ev   = strobing & wb_bus_rty_i & ~wb_bus_err_i;
  assign ack_ev   = strobing & wb_bus_ack_i & ~wb_bus_err_i & ~wb_bus_rty_i;
  assign retry_ok = rty_ev & (int'(retry_reg) < RETRY_LIMIT);
  assign fail_err = (strobing & wb_bus_err_i) | (rty_ev & ~retry_ok & RETRY_EN);
  assign fail_rty = rty_ev & ~retry_ok & ~RETRY_EN;

  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_mask
      assign wmask[gi*8 +: 8] = {8{wb_core_sel_i[gi]}};
    end
    if (AW <= DW) begin : g_adr_narrow
      assign tadr_adr = tadr_reg[AW-1:0];
    end else begin : g_adr_wide
      assign tadr_adr = {{(AW-DW){1'b0}}, tadr_reg};
    end
  endgenerate

  always_comb begin
    new_val    = opb_reg;
    need_write = 1'b0;
    case (op_reg)
      2'd0:    begin new_val = opb_reg;                need_write = (wb_bus_dat_i == opa_reg); end
      2'd1:    begin new_val = opa_reg;                need_write = 1'b1; end
      2'd2:    begin new_val = wb_bus_dat_i + opa_reg; need_write = 1'b1; end
      default: begin new_val = wb_bus_dat_i & opa_reg; need_write = 1'b1; end
    endcase
  end

  always_comb begin
    reg_rd = '0;
    case (reg_idx)
      3'd0:    reg_rd = opa_reg;
      3'd1:    reg_rd = opb_reg;
      3'd2:    reg_rd = tadr_reg;
      3'd3:    reg_rd = {{(DW-2){1'b0}}, op_reg};
      3'd5:    reg_rd = {{(DW-2){1'b0}}, status_reg};
      default: reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req && hit) state_next = exec_rd ? RD : REGACK;
      REGACK:  state_next = IDLE;
      RD:      if (fail_err || fail_rty) state_next = RESP;
               else if (ack_ev)          state_next = need_write ? WR : RESP;
      WR:      if (fail_err || fail_rty || ack_ev) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opa_reg <= '0; opb_reg <= '0; tadr_reg <= '0; rdata_reg <= '0;
      old_reg <= '0; new_reg <= '0; op_reg <= '0; status_reg <= '0;
      resp_kind_reg <= RK_OK; gap_reg <= '0; retry_reg <= '0; dropped_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (req && hit) begin
          if (exec_rd) begin
            gap_reg <= '0; retry_reg <= '0; dropped_reg <= 1'b0; resp_kind_reg <= RK_OK;
          end else begin
            rdata_reg <= reg_rd;
            if (wb_core_we_i) begin
              case (reg_idx)
                3'd0:    opa_reg  <= (opa_reg  & ~wmask) | (wb_core_dat_i & wmask);
                3'd1:    opb_reg  <= (opb_reg  & ~wmask) | (wb_core_dat_i & wmask);
                3'd2:    tadr_reg <= (tadr_reg & ~wmask) | (wb_core_dat_i & wmask);
                3'd3:    op_reg   <= (op_reg & ~wmask[1:0]) | (wb_core_dat_i[1:0] & wmask[1:0]);
                default: ;
              endcase
            end
          end
        end
        RD, WR: begin
          if (!wb_core_cyc_i) dropped_reg <= 1'b1;
          if (gap_reg != 2'd0) gap_reg <= gap_reg - 2'd1;
          if (fail_err) begin
            resp_kind_reg <= RK_ERR;
            status_reg    <= 2'b10;
          end else if (fail_rty) begin
            resp_kind_reg <= RK_RTY;
          end else if (retry_ok) begin
            gap_reg   <= 2'd2;
            retry_reg <= retry_reg + 8'd1;
          end else if (ack_ev) begin
            retry_reg <= '0;
            if (state_reg == RD) begin
              old_reg <= wb_bus_dat_i;
              new_reg <= new_val;
              if (need_write) gap_reg <= 2'd1;
              else            status_reg <= 2'b00;
            end else begin
              status_reg <= 2'b01;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wb_bus_adr_o  = '0; wb_bus_dat_o = '0; wb_bus_sel_o = '0;
    wb_bus_we_o   = 1'b0; wb_bus_cyc_o = 1'b0; wb_bus_stb_o = 1'b0; bus_lock_o = 1'b0;
    wb_core_dat_o = '0; wb_core_ack_o = 1'b0; wb_core_err_o = 1'b0; wb_core_rty_o = 1'b0;
    case (state_reg)
      IDLE: if (req && !hit) begin
        wb_bus_adr_o  = wb_core_adr_i; wb_bus_dat_o = wb_core_dat_i; wb_bus_sel_o = wb_core_sel_i;
        wb_bus_we_o   = wb_core_we_i;  wb_bus_cyc_o = 1'b1;          wb_bus_stb_o = 1'b1;
        wb_core_ack_o = wb_bus_ack_i;  wb_core_err_o = wb_bus_err_i; wb_core_rty_o = wb_bus_rty_i;
        wb_core_dat_o = wb_bus_dat_i;
      end
      REGACK: begin
        wb_core_ack_o = 1'b1;
        wb_core_dat_o = rdata_reg;
      end
      RD, WR: begin
        wb_bus_adr_o = tadr_adr; wb_bus_sel_o = '1;
        wb_bus_cyc_o = 1'b1;     wb_bus_stb_o = strobing; bus_lock_o = 1'b1;
        wb_bus_we_o  = (state_reg == WR);
        wb_bus_dat_o = (state_reg == WR) ? new_reg : '0;
      end
      RESP: if (wb_core_cyc_i && !dropped_reg) begin
        wb_core_ack_o = (resp_kind_reg == RK_OK);
        wb_core_err_o = (resp_kind_reg == RK_ERR);
        wb_core_rty_o = (resp_kind_reg == RK_RTY);
        wb_core_dat_o = (resp_kind_reg == RK_OK) ? old_reg : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_atomic_unit.sv
// Bench for wb_atomic_unit: directed and randomized atomic ops against a reference model,
// with a zero-wait bus slave that can inject err/rty or stall.
`timescale 1ns/1ps
module tb_wb_atomic_unit;
  localparam logic [31:0] WIN = 32'hFFFF_FF00;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] core_adr = '0, core_dat_w = '0, core_dat_r;
  logic [3:0]  core_sel = '0;
  logic        core_we = 1'b0, core_cyc = 1'b0, core_stb = 1'b0;
  logic        core_ack, core_err, core_rty;
  logic [31:0] bus_adr, bus_dat_w, bus_dat_r = '0;
  logic [3:0]  bus_sel;
  logic        bus_we, bus_cyc, bus_stb, bus_lock;
  logic        bus_ack = 1'b0, bus_err = 1'b0, bus_rty = 1'b0;

  wb_atomic_unit dut (
    .clk_i(clk), .rst_i(rst),
    .wb_core_adr_i(core_adr), .wb_core_dat_i(core_dat_w), .wb_core_dat_o(core_dat_r),
    .wb_core_sel_i(core_sel), .wb_core_we_i(core_we), .wb_core_cyc_i(core_cyc),
    .wb_core_stb_i(core_stb), .wb_core_ack_o(core_ack), .wb_core_err_o(core_err),
    .wb_core_rty_o(core_rty),
    .wb_bus_adr_o(bus_adr), .wb_bus_dat_o(bus_dat_w), .wb_bus_dat_i(bus_dat_r),
    .wb_bus_sel_o(bus_sel), .wb_bus_we_o(bus_we), .wb_bus_cyc_o(bus_cyc),
    .wb_bus_stb_o(bus_stb), .wb_bus_ack_i(bus_ack), .wb_bus_err_i(bus_err),
    .wb_bus_rty_i(bus_rty), .bus_lock_o(bus_lock)
  );

  always #5 clk = ~clk;

  // Memory-backed slave answering in the strobe cycle itself
  logic [31:0] mem [logic [31:0]];
  int wr_cnt = 0, rty_left = 0;
  bit stall = 1'b0, err_on_write = 1'b0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    bus_ack = 1'b0; bus_err = 1'b0; bus_rty = 1'b0; bus_dat_r = '0;
    if (bus_cyc && bus_stb && !stall) begin
      if (bus_we && err_on_write) bus_err = 1'b1;
      else if (!bus_we && rty_left > 0) begin bus_rty = 1'b1; rty_left--; end
      else begin
        bus_ack = 1'b1;
        if (bus_we) begin mem[bus_adr] = bus_dat_w; wr_cnt++; end
        else bus_dat_r = rd_mem(bus_adr);
      end
    end
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [31:0] last_dat, last_bus_adr;
  logic [2:0]  last_resp;
  logic        last_cyc, last_lock;
  int          last_cycles, last_nolock;

  task automatic core_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel);
    bit got = 1'b0;
    @(posedge clk); #1;
    core_adr = adr; core_we = we; core_dat_w = dat; core_sel = sel; core_cyc = 1'b1; core_stb = 1'b1;
    last_cycles = 0; last_nolock = 0; last_resp = '0; last_dat = '0;
    while (!got && last_cycles < 40) begin
      @(negedge clk); #1;
      last_cycles++;
      if (core_ack || core_err || core_rty) begin
        got = 1'b1;
        last_resp = {core_rty, core_err, core_ack};
        last_dat = core_dat_r; last_cyc = bus_cyc; last_lock = bus_lock; last_bus_adr = bus_adr;
      end else if (bus_cyc && !bus_lock) last_nolock++;
    end
    check("timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    core_cyc = 1'b0; core_stb = 1'b0; core_we = 1'b0;
    $display("txn adr=%08h we=%0b resp=%03b dat=%08h cycles=%0d", adr, we, last_resp, last_dat, last_cycles);
  endtask

  task automatic reg_write(input logic [7:0] off, input logic [31:0] v);
    core_access(WIN + {24'h0, off}, 1'b1, v, 4'hF);
  endtask

  task automatic reg_read(input logic [7:0] off);
    core_access(WIN + {24'h0, off}, 1'b0, 32'h0, 4'hF);
  endtask

  // Reference: what the operation writes (if anything) given the old memory value
  function automatic void model(input logic [1:0] op, input logic [31:0] a, b, old,
                                output logic [31:0] nv, output bit wr);
    case (op)
      2'd0: begin nv = b; wr = (old == a); end
      2'd1: begin nv = a; wr = 1'b1; end
      2'd2: begin nv = old + a; wr = 1'b1; end
      default: begin nv = old & a; wr = 1'b1; end
    endcase
  endfunction

  task automatic run_atomic(input string name, input logic [1:0] op,
                            input logic [31:0] a, b, ta, old, input int exp_cycles);
    logic [31:0] nv; bit wr; int wr0;
    mem[ta] = old;
    reg_write(8'h00, a); reg_write(8'h04, b); reg_write(8'h08, ta); reg_write(8'h0C, {30'h0, op});
    wr0 = wr_cnt;
    reg_read(8'h10);
    model(op, a, b, old, nv, wr);
    check({name, ":dat"}, last_dat, old);
    check({name, ":resp"}, 32'(last_resp), 32'd1);
    check({name, ":lock"}, 32'(last_nolock), 32'd0);
    check({name, ":released"}, {30'h0, last_cyc, last_lock}, 32'd0);
    check({name, ":writes"}, 32'(wr_cnt - wr0), 32'(wr));
    check({name, ":mem"}, rd_mem(ta), wr ? nv : old);
    if (exp_cycles > 0) check({name, ":latency"}, 32'(last_cycles), 32'(exp_cycles));
    reg_read(8'h14);
    check({name, ":status"}, last_dat, {31'h0, wr});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, old, st;
    logic [1:0]  op;
    int wr0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset:ctl", {25'h0, core_ack, core_err, core_rty, bus_cyc, bus_stb, bus_lock, bus_we}, 32'h0);
    check("reset:dat", core_dat_r, 32'h0);
    check("reset:adr", bus_adr, 32'h0);
    reg_read(8'h00);
    check("reset:opa", last_dat, 32'h0);
    check("regack:latency", 32'(last_cycles), 32'd2);

    reg_write(8'h00, 32'hAABB_CCDD);
    core_access(WIN, 1'b1, 32'h1122_3344, 4'b0010);
    reg_read(8'h00);
    check("bytelane", last_dat, 32'hAABB_33DD);
    reg_write(8'h18, 32'hFFFF_FFFF);
    reg_read(8'h18);
    check("unused_off", last_dat, 32'h0);

    run_atomic("cas_ok",   2'd0, 32'd5, 32'd9, 32'h100, 32'd5, 5);
    run_atomic("cas_fail", 2'd0, 32'd5, 32'd9, 32'h100, 32'd7, 3);
    run_atomic("add_wrap", 2'd2, 32'd2, 32'd0, 32'h104, 32'hFFFF_FFFF, 5);

    // Pass-through must not touch window registers
    mem[32'h2000] = 32'h1234_5678;
    core_access(32'h2000, 1'b0, 32'h0, 4'hF);
    check("pt:dat", last_dat, 32'h1234_5678);
    check("pt:adr", last_bus_adr, 32'h2000);
    check("pt:latency", 32'(last_cycles), 32'd1);
    core_access(32'h2004, 1'b1, 32'hCAFE_F00D, 4'hF);
    check("pt:wr", rd_mem(32'h2004), 32'hCAFE_F00D);
    reg_read(8'h00);
    check("pt:opa_kept", last_dat, 32'd2);

    // SWAP with err on the write phase
    mem[32'h108] = 32'h55;
    reg_write(8'h00, 32'h77); reg_write(8'h08, 32'h108); reg_write(8'h0C, 32'd1);
    err_on_write = 1'b1; wr0 = wr_cnt;
    reg_read(8'h10);
    err_on_write = 1'b0;
    check("err:resp", 32'(last_resp), 32'd2);
    check("err:released", {30'h0, last_cyc, last_lock}, 32'd0);
    @(negedge clk); #1;
    check("err:one_cycle", 32'(core_err), 32'd0);
    check("err:nowrite", 32'(wr_cnt - wr0), 32'd0);
    check("err:mem", rd_mem(32'h108), 32'h55);
    reg_read(8'h14);
    check("err:status", last_dat, 32'd2);

    // Retry: two rty during the read phase
    run_atomic("pre_rty", 2'd0, 32'd3, 32'd4, 32'h10C, 32'd8, 0);
    reg_read(8'h14); st = last_dat;
    mem[32'h10C] = 32'd3; rty_left = 2; wr0 = wr_cnt;
    reg_read(8'h10);
`ifdef WB_ATOMIC_RETRY_EN
    check("rty:resp", 32'(last_resp), 32'd1);
    check("rty:dat", last_dat, 32'd3);
    check("rty:mem", rd_mem(32'h10C), 32'd4);
    check("rty:writes", 32'(wr_cnt - wr0), 32'd1);
    st = 32'd1;
`else
    check("rty:resp", 32'(last_resp), 32'd4);
    check("rty:mem", rd_mem(32'h10C), 32'd3);
    check("rty:writes", 32'(wr_cnt - wr0), 32'd0);
`endif
    rty_left = 0;
    reg_read(8'h14);
    check("rty:status", last_dat, st);

    // Randomized operations
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom; old = $urandom;
      if (op == 2'd0 && $urandom_range(0, 1) == 1) old = a;
      run_atomic($sformatf("rnd%0d", i), op, a, b, 32'h200 + 32'(i * 4), old, 0);
    end

    // Reset while the read phase is stalled
    mem[32'h300] = 32'hDEAD; reg_write(8'h08, 32'h300); reg_write(8'h0C, 32'd1);
    stall = 1'b1; wr0 = wr_cnt;
    @(posedge clk); #1;
    core_adr = WIN + 32'h10; core_we = 1'b0; core_sel = 4'hF; core_cyc = 1'b1; core_stb = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("rst:in_rd", {30'h0, bus_cyc, bus_lock}, 32'd3);
    @(posedge clk); #1 rst = 1'b1; core_cyc = 1'b0; core_stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst:released", {30'h0, bus_cyc, bus_lock}, 32'd0);
    stall = 1'b0;
    repeat (2) @(posedge clk);
    check("rst:nowrite", 32'(wr_cnt - wr0), 32'd0);
    check("rst:mem", rd_mem(32'h300), 32'hDEAD);
    reg_read(8'h08);
    check("rst:tadr_cleared", last_dat, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
